// File: rtl/color_palette.sv
// rtl/color_palette.sv - shared palette, mode and FSM state constants for color_code_gen
package color_palette;

    localparam logic [11:0] COLOR_0 = 12'hFFF;
    localparam logic [11:0] COLOR_1 = 12'hF00;
    localparam logic [11:0] COLOR_2 = 12'h0F0;
    localparam logic [11:0] COLOR_3 = 12'h00F;
    localparam logic [11:0] COLOR_4 = 12'hE1F;
    localparam logic [11:0] COLOR_5 = 12'hFC0;
    localparam logic [11:0] COLOR_6 = 12'h940;
    localparam logic [11:0] COLOR_7 = 12'h3DF;
    localparam logic [11:0] COLOR_8 = 12'h250;
    localparam logic [11:0] COLOR_9 = 12'h92E;

    localparam logic [11:0] COLOR_BLANK = 12'h000;
    localparam logic [11:0] COLOR_INV_MASK = 12'hFFF;

    // Mode 3 is not decoded anywhere, so it behaves exactly like MODE_NORMAL.
    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_BLANK  = 2'd1;
    localparam logic [1:0] MODE_INVERT = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_MAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Number of BCD digits needed to hold any WIDTH-bit value: at least DIGITS,
    // and enough (ceil(WIDTH/3)) that the double-dabble shifts never lose bits.
    function automatic int int_digits(input int width, input int digits);
        int need;
        need = (width + 2) / 3;
        return (digits > need) ? digits : need;
    endfunction

endpackage

// File: rtl/color_digit_lut.sv
// rtl/color_digit_lut.sv - one decimal digit to 12-bit RGB colour lookup
module color_digit_lut
    import color_palette::*;
(
    input  logic [3:0]  digit,
    output logic [11:0] color
);

    // Pure lookup; codes 10..15 never come out of a valid BCD register.
    always_comb begin
        color = COLOR_BLANK;
        case (digit)
            4'd0: color = COLOR_0;
            4'd1: color = COLOR_1;
            4'd2: color = COLOR_2;
            4'd3: color = COLOR_3;
            4'd4: color = COLOR_4;
            4'd5: color = COLOR_5;
            4'd6: color = COLOR_6;
            4'd7: color = COLOR_7;
            4'd8: color = COLOR_8;
            4'd9: color = COLOR_9;
            default: color = COLOR_BLANK;
        endcase
    end

endmodule

// File: rtl/color_code_gen.sv
// rtl/color_code_gen.sv - sequential binary-to-BCD colour code generator with handshakes
module color_code_gen
    import color_palette::*;
#(
    parameter int          WIDTH     = 6,
    parameter int          DIGITS    = 2,
    parameter logic [11:0] OVF_COLOR = 12'h888
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      num,
    input  logic [1:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [12*DIGITS-1:0]  code,
    output logic                  overflow
);

    localparam int INT_DIGITS = int_digits(WIDTH, DIGITS);
    localparam int BW         = 4 * INT_DIGITS;
    localparam int CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    logic [1:0]            state_q;
    logic [WIDTH-1:0]      num_q;
    logic [1:0]            mode_q;
    logic [BW-1:0]         bcd_q;
    logic [CW-1:0]         cnt_q;
    logic [12*DIGITS-1:0]  code_q;
    logic                  ovf_q;
    logic                  out_valid_q;

    logic [BW-1:0]         bcd_adj;
    logic                  ovf_next;
    logic [12*DIGITS-1:0]  code_next;
    logic [11:0]           lut_color [DIGITS];

    // Double-dabble correction: any digit >= 5 gets +3 before the next shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_lut
            color_digit_lut u_lut (
                .digit (bcd_q[4*g +: 4]),
                .color (lut_color[g])
            );
        end
    endgenerate

    // Overflow when any hidden upper BCD digit holds a non-zero value.
    always_comb begin
        ovf_next = 1'b0;
        for (int i = DIGITS; i < INT_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                ovf_next = 1'b1;
            end
        end
    end

    // Per-digit colour: blanking walks down from the top digit, then inversion, overflow wins.
    always_comb begin
        logic        seen_nz;
        logic [11:0] col;
        seen_nz   = 1'b0;
        col       = COLOR_BLANK;
        code_next = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            col = lut_color[i];
            if (mode_q == MODE_BLANK && !seen_nz && i != 0) begin
                col = COLOR_BLANK;
            end
            if (mode_q == MODE_INVERT) begin
                col = col ^ COLOR_INV_MASK;
            end
            if (ovf_next) begin
                col = OVF_COLOR;
            end
            code_next[12*i +: 12] = col;
        end
    end

    // Control FSM plus the shift datapath and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            mode_q      <= MODE_NORMAL;
            bcd_q       <= '0;
            cnt_q       <= '0;
            code_q      <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        num_q   <= num;
                        mode_q  <= mode;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_INIT;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_q <= {bcd_adj[BW-2:0], num_q[WIDTH-1]};
                    num_q <= num_q << 1;
                    cnt_q <= cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_MAP;
                    end
                end
                ST_MAP: begin
                    code_q      <= code_next;
                    ovf_q       <= ovf_next;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                default: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign code      = code_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_color_code_gen.sv
// tb/tb_color_code_gen.sv - directed self-checking bench for color_code_gen
module tb_color_code_gen;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, overflow;
    logic [5:0]  num;
    logic [1:0]  mode;
    logic [23:0] code;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_overflow;
    logic [7:0]  b_num;
    logic [1:0]  b_mode;
    logic [23:0] b_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    color_code_gen dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .num(num), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .code(code), .overflow(overflow)
    );

    color_code_gen #(.WIDTH(8), .DIGITS(2), .OVF_COLOR(12'h888)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .num(b_num), .mode(b_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .code(b_code), .overflow(b_overflow)
    );

    task automatic conv(input logic [5:0] n, input logic [1:0] m, output int lat);
        @(negedge clk);
        num = n; mode = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic conv8(input logic [7:0] n, input logic [1:0] m, output int lat);
        @(negedge clk);
        b_num = n; b_mode = m; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_valid !== 1'b0 || code !== 24'h0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: out_valid=%b code=%h overflow=%b in_ready=%b want 0 000000 0 1",
                     out_valid, code, overflow, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_in_ready_idle: got %b want 1", in_ready);
        end
        conv(6'd42, 2'd0, lat);
        checks++;
        if (lat !== 7) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 7", lat);
        end
        checks++;
        if (code !== 24'hE1F0F0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_code: got %h ovf %b want E1F0F0 ovf 0", code, overflow);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_in_ready_done: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_handshake: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_modes();
        logic [5:0]  nums  [6] = '{6'd7, 6'd7, 6'd0, 6'd63, 6'd42, 6'd0};
        logic [1:0]  modes [6] = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [23:0] exp   [6] = '{24'h0003DF, 24'hFFF3DF, 24'h000FFF, 24'h6BFFF0, 24'hE1F0F0, 24'hFFFFFF};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            conv(nums[i], modes[i], lat);
            checks++;
            if (lat !== 7 || code !== exp[i] || overflow !== 1'b0) begin
                errors++;
                $display("FAIL mode_vec%0d: num=%0d mode=%0d got code %h ovf %b lat %0d want %h 0 7",
                         i, nums[i], modes[i], code, overflow, lat, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_overflow();
        logic [7:0]  nums  [5] = '{8'd200, 8'd99, 8'd100, 8'd255, 8'd5};
        logic [1:0]  modes [5] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd1};
        logic [23:0] exp   [5] = '{24'h888888, 24'h92E92E, 24'h888888, 24'h888888, 24'h000FC0};
        logic        eovf  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat;
        b_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            conv8(nums[i], modes[i], lat);
            checks++;
            if (lat !== 9 || b_code !== exp[i] || b_overflow !== eovf[i]) begin
                errors++;
                $display("FAIL ovf_vec%0d: num=%0d got code %h ovf %b lat %0d want %h %b 9",
                         i, nums[i], b_code, b_overflow, lat, exp[i], eovf[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int rises;
        out_ready = 1'b0;
        conv(6'd42, 2'd0, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            num = 6'd5; mode = 2'd0; in_valid = (i % 2 == 0);
            checks++;
            if (out_valid !== 1'b1 || code !== 24'hE1F0F0 || overflow !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: out_valid=%b code=%h ovf=%b in_ready=%b want 1 E1F0F0 0 0",
                         i, out_valid, code, overflow, in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || code !== 24'hE1F0F0) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b code=%h want 0 1 E1F0F0",
                     out_valid, in_ready, code);
        end
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        checks++;
        if (rises !== 0) begin
            errors++;
            $display("FAIL bp_ignored_in_valid: out_valid seen %0d cycles want 0", rises);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b1;
        @(negedge clk);
        num = 6'd42; mode = 2'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || code !== 24'h0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%b code=%h ovf=%b in_ready=%b want 0 000000 0 1",
                     out_valid, code, overflow, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        conv(6'd15, 2'd0, lat);
        checks++;
        if (lat !== 7 || code !== 24'hF00FC0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_recover: code=%h ovf=%b lat=%0d want F00FC0 0 7", code, overflow, lat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; num = '0; mode = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_num = '0; b_mode = '0; b_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_modes();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
